// File: rtl/approx_mul_err_monitor_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
package approx_mul_err_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One spare bit above the wider operand captures the carry-out.
    localparam int SAT_GUARD_W = 1;

    function automatic int max_w(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/approx_mul_err_monitor_sat_acc.sv
// Saturating accumulator: clear has priority, sticks at all-ones once it overflows.
module approx_err_sat_acc
    import approx_mul_err_monitor_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int VAL_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [VAL_W-1:0] value,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    localparam int SUM_W = max_w(ACC_W, VAL_W) + SAT_GUARD_W;

    logic [SUM_W-1:0] ext;
    logic             ovf;

    assign ext = SUM_W'(sum) + SUM_W'(value);
    assign ovf = |ext[SUM_W-1:ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            sat <= 1'b0;
        end else if (add_en) begin
            if (ovf || sat) begin
                sum <= '1;
                sat <= 1'b1;
            end else begin
                sum <= ext[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Error-statistics monitor for an approximate multiplier (three-stage pipeline).
// Optional squared-error sum is built when ERR_SQ_EN is defined.
module approx_mul_err_monitor
    import approx_mul_err_monitor_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2*W-1:0]   in_prod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2*W-1:0]   max_err,
    output logic [ACC_W-1:0] sum_err
`ifdef ERR_SQ_EN
    ,
    output logic [ACC_W-1:0] sum_sq_err
`endif
);

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] next_acc;
    logic             accept;
    logic             run_start;

    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [2*W-1:0]   s1_prod;
    logic             s1_v;
    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   err_c;
    logic [2*W-1:0]   s2_err;
    logic             s2_v;
    logic             sum_sat;

    assign in_ready  = (state == ST_RUN) && (accepted < target);
    assign accept    = in_valid && in_ready;
    assign next_acc  = accepted + 1'b1;
    assign run_start = start &&
                       ((state == ST_IDLE) || (state == ST_DONE));

    assign exact = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b};
    assign err_c = (exact >= s1_prod) ? (exact - s1_prod)
                                      : (s1_prod - exact);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            target   <= '0;
            accepted <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        target   <= num_samples;
                        accepted <= '0;
                        if (num_samples != '0) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        accepted <= next_acc;
                        if (next_acc == target) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Empty once the last sample has left S2 into the stats.
                    if (!s1_v && !s2_v) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_prod <= '0;
            s1_v    <= 1'b0;
            s2_err  <= '0;
            s2_v    <= 1'b0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_prod <= in_prod;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_err <= err_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_err    <= '0;
        end else if (run_start) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_err    <= '0;
        end else if (s2_v) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (s2_err != '0) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (s2_err > max_err) begin
                max_err <= s2_err;
            end
        end
    end

    approx_err_sat_acc #(
        .ACC_W (ACC_W),
        .VAL_W (2*W)
    ) u_sum_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (run_start),
        .add_en (s2_v && !sum_sat),
        .value  (s2_err),
        .sum    (sum_err),
        .sat    (sum_sat)
    );

`ifdef ERR_SQ_EN
    logic [4*W-1:0] sq;
    logic           sq_sat;

    assign sq = {{(2*W){1'b0}}, s2_err} * {{(2*W){1'b0}}, s2_err};

    approx_err_sat_acc #(
        .ACC_W (ACC_W),
        .VAL_W (4*W)
    ) u_sq_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (run_start),
        .add_en (s2_v && !sq_sat),
        .value  (sq),
        .sum    (sum_sq_err),
        .sat    (sq_sat)
    );
`endif

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Scoreboard bench for approx_mul_err_monitor (small accumulator to reach saturation).
module tb_approx_mul_err_monitor;

    localparam int W     = 16;
    localparam int ACC_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [2*W-1:0]   in_prod = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [2*W-1:0]   max_err;
    logic [ACC_W-1:0] sum_err;
`ifdef ERR_SQ_EN
    logic [ACC_W-1:0] sum_sq_err;
`endif

    approx_mul_err_monitor #(
        .W     (W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_prod     (in_prod),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .max_err     (max_err),
        .sum_err     (sum_err)
`ifdef ERR_SQ_EN
        ,
        .sum_sq_err  (sum_sq_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int     n;
        int     e;
        longint mx;
        longint sum;
        longint sq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input longint act,
                                input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic void push(input int n, input int e, input longint mx,
                                 input longint sum, input longint sq);
        exp_t x;
        x.n = n; x.e = e; x.mx = mx; x.sum = sum; x.sq = sq;
        exp_q.push_back(x);
    endfunction

    // Monitor: compares final statistics on every rising edge of done.
    initial begin
        logic prev;
        exp_t x;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("sample_cnt", sample_cnt, x.n);
                    chk("err_cnt", err_cnt, x.e);
                    chk("max_err", max_err, x.mx);
                    chk("sum_err", sum_err, x.sum);
`ifdef ERR_SQ_EN
                    chk("sum_sq_err", sum_sq_err, x.sq);
`endif
                end
            end
            prev = done;
        end
    end

    task automatic start_run(input int n);
        @(negedge clk);
        num_samples = CNT_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n != 0) chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int n, input int off, input bit gaps,
                        input bit check_done);
        int acc;
        int guard;
        int k;
        logic [31:0] p;
        acc = 0;
        guard = 0;
        while (acc < n && guard < 400) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_a = W'($urandom_range(3, 65535));
            in_b = W'($urandom_range(3, 65535));
            p = 32'(in_a) * 32'(in_b);
            in_prod = p + 32'(off);
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("accepted", acc, n);
        if (check_done) begin
            chk("ready_after_last", in_ready, 0);
            k = 0;
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("done_latency", k + 1, 4);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_max_err", max_err, 0);
        chk("rst_sum_err", sum_err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        push(20, 0, 0, 0, 0);
        start_run(20);
        feed(20, 0, 1'b0, 1'b1);

        push(10, 10, 5, 50, 250);
        start_run(10);
        feed(10, 5, 1'b0, 1'b1);

        push(10, 10, 7, 70, 255);
        start_run(10);
        feed(10, -7, 1'b0, 1'b1);

        push(8, 0, 0, 0, 0);
        start_run(8);
        feed(8, 0, 1'b1, 1'b1);

        start_run(10);
        feed(3, 3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sample_cnt", sample_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_max_err", max_err, 0);
        chk("mid_rst_sum_err", sum_err, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_sample_cnt", sample_cnt, 0);
        chk("post_rst_ready", in_ready, 0);

        push(0, 0, 0, 0, 0);
        start_run(0);
        chk("zero_done", done, 1);
        chk("zero_ready", in_ready, 0);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_ready_later", in_ready, 0);

        push(3, 3, 100, 255, 255);
        start_run(3);
        feed(3, 100, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
